// File: rtl/shifter8_pkg.sv
// Shared definitions for the shifter8 sequencing stage: op codes, FSM state
// encoding and default widths.
// Optional feature macro: SHIFTER8_SERIAL_IN_EN (adds serial_in fill for LSL/LSR).
package shifter8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_LSL  = 3'd2;
  localparam logic [2:0] OP_LSR  = 3'd3;
  localparam logic [2:0] OP_ASR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  // Shift ops are the ones that run through the SHIFT state.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_LSL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shifter8_seq_if.sv
// Command/status bundle between the command source and shifter8_seq.
// Optional feature macro: SHIFTER8_SERIAL_IN_EN (adds serial_in).
interface shifter8_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef SHIFTER8_SERIAL_IN_EN
  logic             serial_in;

  modport master (output start, op, amount, d_in, serial_in, input q, busy, done);
  modport slave  (input start, op, amount, d_in, serial_in, output q, busy, done);
`else
  modport master (output start, op, amount, d_in, input q, busy, done);
  modport slave  (input start, op, amount, d_in, output q, busy, done);
`endif
endinterface

// File: rtl/shift8_step.sv
// One 1-bit step of a shift/rotate op; non-shift ops pass the value through.
module shift8_step
  import shifter8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] q_o
);

  // Select the single-step result for the requested op.
  always_comb begin
    q_o = q_i;
    case (op_i)
      OP_LSL:  q_o = {q_i[WIDTH-2:0], fill_i};
      OP_LSR:  q_o = {fill_i, q_i[WIDTH-1:1]};
      OP_ASR:  q_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      OP_ROL:  q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      OP_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
      default: q_o = q_i;
    endcase
  end

endmodule

// File: rtl/shifter8_seq.sv
// Sequencing stage ahead of the shifter8 state register: accepts LOAD or a
// multi-step shift command in IDLE, steps one bit per clock in SHIFT, and
// pulses done for one cycle in FIN.
// Optional feature macro: SHIFTER8_SERIAL_IN_EN (LSL/LSR fill from serial_in).
module shifter8_seq
  import shifter8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  shifter8_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, step_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             fill;

`ifdef SHIFTER8_SERIAL_IN_EN
  assign fill = bus.serial_in;
`else
  assign fill = 1'b0;
`endif

  // The step unit always works on the latched op so mid-shift bus changes are inert.
  shift8_step #(.WIDTH(WIDTH)) u_step (
    .q_i    (q_q),
    .op_i   (op_q),
    .fill_i (fill),
    .q_o    (step_q)
  );

  // State, value, remaining count and latched op registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state and datapath selection; everything holds unless a state acts.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_LOAD) begin
            q_d     = bus.d_in;
            state_d = ST_FIN;
          end else if (is_shift_op(bus.op) && (bus.amount != '0)) begin
            op_d    = bus.op;
            cnt_d   = bus.amount;
            state_d = ST_SHIFT;
          end else begin
            // NOP, reserved, or zero-length shift: complete without touching q.
            state_d = ST_FIN;
          end
        end
      end
      ST_SHIFT: begin
        q_d   = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.q    = q_q;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_FIN);

endmodule

// File: doc/shifter8_seq.md
Name: shifter8_seq

Overview:
- Sequencing stage directly upstream of the 8-bit state register in the shifter8 counter path.
- Accepts a load or shift command and computes the next register value, one bit position per clock.
- Tracks the remaining shift count and reports busy/done.
- Holds the current value internally and presents it on q, which feeds the downstream register stage / display.

Parameters:
- WIDTH, 8, data width; only 8 is verified.
- CNT_W, 3, width of the shift-amount field; maximum amount is 7.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- op  in  3  command: 0 NOP, 1 LOAD, 2 LSL, 3 LSR, 4 ASR, 5 ROL, 6 ROR, 7 reserved (treated as NOP)
- amount  in  CNT_W  number of 1-bit steps for shift ops; ignored for LOAD/NOP
- d_in  in  WIDTH  load data
- q  out  WIDTH  current value, registered
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-high on port reset.
- While reset is asserted: q=8'h00, busy=0, done=0, state=IDLE, cnt=0, op_r=NOP.
- FSM states and transitions:
  - IDLE + start + LOAD: q<=d_in, go to FIN.
  - IDLE + start + shift op + amount!=0: latch op into op_r, cnt<=amount, go to SHIFT.
  - IDLE + start + shift op + amount==0: q unchanged, go to FIN.
  - IDLE + start + NOP/reserved: go to FIN, q unchanged.
  - IDLE, no start: hold.
  - SHIFT: each cycle apply one step of op_r to q and decrement cnt. When cnt==1 at the clock edge, perform the final step and go to FIN.
  - FIN: done=1 for exactly this cycle, then go to IDLE.
- Step definitions (one bit per step):
  - LSL: {q[6:0],fill}
  - LSR: {fill,q[7:1]}
  - ASR: {q[7],q[7:1]}
  - ROL: {q[6:0],q[7]}
  - ROR: {q[0],q[7:1]}
  - fill=0 unless the optional feature is enabled.
- Latency: a shift of N≥1 completes with q final N cycles after the start edge; done is asserted on cycle N+1. LOAD/NOP/amount 0: done asserted the cycle after start.
- busy=1 only in SHIFT; q is intermediate while busy.
- start while busy or in FIN: ignored, not queued. op/amount/d_in changes during SHIFT have no effect (op_r latched).
- A new start accepted in the IDLE cycle immediately following FIN (back-to-back rate: 1 command per N+2 cycles).
- Reset mid-SHIFT: immediate return to reset values; no done pulse.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro SHIFTER8_SERIAL_IN_EN.
- Defined: adds input port serial_in (1 bit); fill for LSL/LSR = serial_in sampled each SHIFT cycle.
- Undefined: no serial_in port; fill=0.
- ASR/ROL/ROR are unaffected either way.

Decomposition:
- Package shifter8_pkg holds:
  - op code localparams (OP_NOP..OP_ROR)
  - FSM state encoding (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_FIN=2'd2)
  - WIDTH/CNT_W defaults
- One natural sub-module: shift8_step, purely combinational (q, op, fill -> next q). Instantiated once in shifter8_seq; reused by the testbench reference model.

Test Plan:
- Reset, then LOAD d_in=8'hA5 -> q=8'hA5 one cycle after start, done pulses 1 cycle, busy never high.
- From q=8'hA5, ROL amount=3 -> busy for 3 cycles, q sequence 4B,96,2D, done on cycle 4, then IDLE.
- From q=8'h81, ASR amount=7 -> final q=8'hFF; same start with LSR -> final q=8'h01; LSR amount=0 -> q unchanged, done next cycle.
- During LSL amount=5, pulse start with LOAD 8'h00 at cycle 2 -> ignored, shift completes normally, q=8'hA0 from 8'h85.
- Assert reset at cycle 2 of ROR amount=6 -> q=00, busy=0, done never pulses; the next command after deassert runs normally.
- With SHIFTER8_SERIAL_IN_EN, q=8'h00, LSL amount=4, serial_in=1 -> q=8'h0F; without the macro, same stimulus -> q=8'h00.
